// File: rtl/enc_pwm_pkg.sv
// Shared types and constants for the encoder PWM capture array.
package enc_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_HIGH,
    ST_LOW
  } cap_state_e;

  // All-ones value of a counter of the given width; also correct for width 32.
  function automatic int unsigned default_timeout(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  localparam int unsigned ENC_PWM_DWIDTH_DEF  = 20;
  localparam int unsigned ENC_PWM_TIMEOUT_DEF = default_timeout(ENC_PWM_DWIDTH_DEF);

endpackage

// File: rtl/pwm_capture_chan.sv
// One PWM capture channel: pin synchroniser, registered edge detector and
// IDLE/ARM/HIGH/LOW measurement FSM producing high time and period.
module pwm_capture_chan
  import enc_pwm_pkg::*;
#(
  parameter int unsigned K_DWIDTH  = ENC_PWM_DWIDTH_DEF,
  parameter int unsigned K_TIMEOUT = ENC_PWM_TIMEOUT_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_pwm,
  input  logic                i_start,
  input  logic                i_clear,
  input  logic                i_continuous,
  output logic [K_DWIDTH-1:0] o_high,
  output logic [K_DWIDTH-1:0] o_period,
  output logic                o_valid,
  output logic                o_done,
  output logic                o_timeout,
  output logic                o_busy
);

  localparam logic [K_DWIDTH-1:0] TMO = K_DWIDTH'(K_TIMEOUT);
  localparam logic [K_DWIDTH-1:0] ONE = K_DWIDTH'(1);

  cap_state_e state_q, state_d;

  logic                sync1_q, sync2_q, prev_q;
  logic                rise_q, rise_d, fall_q, fall_d;
  logic [K_DWIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [K_DWIDTH-1:0] hcap_q, hcap_d;
  logic [K_DWIDTH-1:0] high_q, high_d, period_q, period_d;
  logic                valid_q, valid_d, done_q, done_d, tmo_q, tmo_d;
  logic                cnt_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hcap_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      sync1_q  <= i_pwm;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcap_q   <= hcap_d;
      high_q   <= high_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
    end
  end

  // The counter runs from the rising-edge detect through HIGH and LOW, so at
  // the closing rising edge it already holds the period.
  always_comb begin
    rise_d   = sync2_q & ~prev_q;
    fall_d   = ~sync2_q & prev_q;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + ONE;
    cnt_hit  = (cnt_inc == TMO);
    state_d  = state_q;
    cnt_d    = cnt_inc;
    hcap_d   = hcap_q;
    high_d   = high_q;
    period_d = period_q;
    valid_d  = 1'b0;
    done_d   = done_q;
    tmo_d    = tmo_q;
    if (i_clear) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      hcap_d   = '0;
      high_d   = '0;
      period_d = '0;
      done_d   = 1'b0;
      tmo_d    = 1'b0;
    end else if (i_start) begin
      state_d = ST_ARM;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: cnt_d = '0;
        ST_ARM: begin
          if (rise_q) begin
            state_d = ST_HIGH;
            cnt_d   = ONE;
          end else if (cnt_hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmo_d   = 1'b1;
          end
        end
        ST_HIGH: begin
          if (fall_q) begin
            state_d = ST_LOW;
            hcap_d  = cnt_q;
          end else if (cnt_hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmo_d   = 1'b1;
          end
        end
        ST_LOW: begin
          if (rise_q) begin
            high_d   = hcap_q;
            period_d = cnt_q;
            valid_d  = 1'b1;
            done_d   = 1'b1;
            state_d  = i_continuous ? ST_HIGH : ST_IDLE;
            cnt_d    = ONE;
          end else if (cnt_hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmo_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_busy    = (state_q != ST_IDLE);
    o_high    = high_q;
    o_period  = period_q;
    o_valid   = valid_q;
    o_done    = done_q;
    o_timeout = tmo_q;
  end

endmodule

// File: rtl/enc_pwm_capture_array.sv
// Array of independent encoder PWM capture channels with packed result buses.
module enc_pwm_capture_array
  import enc_pwm_pkg::*;
#(
  parameter int unsigned K_NCHAN   = 2,
  parameter int unsigned K_DWIDTH  = ENC_PWM_DWIDTH_DEF,
  parameter int unsigned K_TIMEOUT = default_timeout(K_DWIDTH)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [K_NCHAN-1:0]                 i_pwm,
  input  logic [K_NCHAN-1:0]                 i_start,
  input  logic [K_NCHAN-1:0]                 i_clear,
  input  logic                               i_continuous,
  output logic [K_NCHAN-1:0][K_DWIDTH-1:0]   o_high,
  output logic [K_NCHAN-1:0][K_DWIDTH-1:0]   o_period,
  output logic [K_NCHAN-1:0]                 o_valid,
  output logic [K_NCHAN-1:0]                 o_done,
  output logic [K_NCHAN-1:0]                 o_timeout,
  output logic [K_NCHAN-1:0]                 o_busy
);

  for (genvar g = 0; g < K_NCHAN; g++) begin : g_chan
    pwm_capture_chan #(
      .K_DWIDTH  (K_DWIDTH),
      .K_TIMEOUT (K_TIMEOUT)
    ) u_chan (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_pwm        (i_pwm[g]),
      .i_start      (i_start[g]),
      .i_clear      (i_clear[g]),
      .i_continuous (i_continuous),
      .o_high       (o_high[g]),
      .o_period     (o_period[g]),
      .o_valid      (o_valid[g]),
      .o_done       (o_done[g]),
      .o_timeout    (o_timeout[g]),
      .o_busy       (o_busy[g])
    );
  end

endmodule

// File: tb/tb_enc_pwm_capture_array.sv
// Bench for enc_pwm_capture_array: table-driven captures, directed corner
// sequences and randomized duty/period rows against a waveform-level model.
module tb_enc_pwm_capture_array;

  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 20;
  localparam int unsigned TMO = 1000;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NCH-1:0]          pwm, start, clear;
  logic                    cont;
  logic [NCH-1:0][DW-1:0]  o_high, o_period;
  logic [NCH-1:0]          o_valid, o_done, o_timeout, o_busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  int unsigned t0;

  bit          gen_en [NCH];
  int unsigned gen_t0 [NCH];
  int unsigned gen_h  [NCH];
  int unsigned gen_p  [NCH];

  typedef struct {
    int unsigned ch;
    int unsigned t;
    int unsigned h;
    int unsigned p;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    logic [1:0]  mask;
    bit          cont;
    int unsigned h0, p0, h1, p1, nsched;
    int unsigned en0, eh0, ep0, en1, eh1, ep1;
  } vec_t;
  vec_t tbl [3];

  enc_pwm_capture_array #(
    .K_NCHAN   (NCH),
    .K_DWIDTH  (DW),
    .K_TIMEOUT (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pwm        (pwm),
    .i_start      (start),
    .i_clear      (clear),
    .i_continuous (cont),
    .o_high       (o_high),
    .o_period     (o_period),
    .o_valid      (o_valid),
    .o_done       (o_done),
    .o_timeout    (o_timeout),
    .o_busy       (o_busy)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ideal PWM source: high for h cycles at the start of every p-cycle period.
  initial begin
    pwm = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++)
        pwm[c] = gen_en[c] && (cyc >= gen_t0[c]) && (((cyc - gen_t0[c]) % gen_p[c]) < gen_h[c]);
    end
  end

  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NCH; c++)
      if (o_valid[c] === 1'b1)
        evq.push_back('{ch: c, t: cyc, h: 32'(o_high[c]), p: 32'(o_period[c])});
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) step();
  endtask

  function automatic int unsigned count_ev(input int unsigned c);
    int unsigned n = 0;
    foreach (evq[i]) if (evq[i].ch == c) n++;
    return n;
  endfunction

  task automatic clear_all();
    clear = '1;
    step();
    clear = '0;
    evq.delete();
  endtask

  task automatic start_pulse(input logic [1:0] m);
    start = m;
    step();
    start = '0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned hh [2];
    int unsigned pp [2];
    int unsigned en [2];
    int unsigned eh [2];
    int unsigned ep [2];
    int unsigned pmax, tend, k;
    hh = '{v.h0, v.h1};
    pp = '{v.p0, v.p1};
    en = '{v.en0, v.en1};
    eh = '{v.eh0, v.eh1};
    ep = '{v.ep0, v.ep1};
    for (int c = 0; c < NCH; c++) gen_en[c] = 1'b0;
    cont = v.cont;
    repeat (8) step();
    clear_all();
    t0   = cyc + 12;
    pmax = 1;
    for (int c = 0; c < NCH; c++)
      if (v.mask[c]) begin
        gen_t0[c] = t0;
        gen_h[c]  = hh[c];
        gen_p[c]  = pp[c];
        gen_en[c] = 1'b1;
        if (pp[c] > pmax) pmax = pp[c];
      end
    wait_until(t0 - 5);
    start_pulse(v.mask);
    tend = t0 + v.nsched * pmax + 24;
    wait_until(tend);
    @(negedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      k = 0;
      foreach (evq[i])
        if (evq[i].ch == c) begin
          k++;
          chk($sformatf("%s ch%0d valid_cycle#%0d", tag, c, k), evq[i].t, t0 + k * pp[c] + 4);
          chk($sformatf("%s ch%0d o_high#%0d", tag, c, k), evq[i].h, eh[c]);
          chk($sformatf("%s ch%0d o_period#%0d", tag, c, k), evq[i].p, ep[c]);
        end
      chk($sformatf("%s ch%0d valid_count", tag, c), k, en[c]);
      chk($sformatf("%s ch%0d o_done", tag, c), 32'(o_done[c]), (en[c] > 0) ? 1 : 0);
      chk($sformatf("%s ch%0d o_busy", tag, c), 32'(o_busy[c]), (en[c] > 0 && v.cont) ? 1 : 0);
    end
  endtask

  initial begin
    int unsigned s;
    vec_t rv;
    rst   = 1'b1;
    start = '0;
    clear = '0;
    cont  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      gen_en[c] = 1'b0;
      gen_t0[c] = 0;
      gen_h[c]  = 0;
      gen_p[c]  = 1;
    end

    tbl[0] = '{mask: 2'b01, cont: 1'b0, h0: 100, p0: 400, h1: 0, p1: 1, nsched: 1,
               en0: 1, eh0: 100, ep0: 400, en1: 0, eh1: 0, ep1: 0};
    tbl[1] = '{mask: 2'b01, cont: 1'b1, h0: 150, p0: 400, h1: 0, p1: 1, nsched: 3,
               en0: 3, eh0: 150, ep0: 400, en1: 0, eh1: 0, ep1: 0};
    tbl[2] = '{mask: 2'b11, cont: 1'b0, h0: 50, p0: 200, h1: 300, p1: 500, nsched: 1,
               en0: 1, eh0: 50, ep0: 200, en1: 1, eh1: 300, ep1: 500};

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("reset ch%0d o_high", c), 32'(o_high[c]), 0);
      chk($sformatf("reset ch%0d o_period", c), 32'(o_period[c]), 0);
      chk($sformatf("reset ch%0d flags", c),
          32'({o_valid[c], o_done[c], o_timeout[c], o_busy[c]}), 0);
    end

    for (int r = 0; r < 3; r++) run_vec(tbl[r], $sformatf("tbl%0d", r));

    // Timeout in ARM with the pin held low; earlier results must survive.
    for (int c = 0; c < NCH; c++) gen_en[c] = 1'b0;
    cont = 1'b0;
    repeat (8) step();
    evq.delete();
    s = cyc;
    start_pulse(2'b01);
    wait_until(s + 1000);
    @(negedge clk);
    chk("tmo before o_timeout", 32'(o_timeout[0]), 0);
    chk("tmo before o_busy", 32'(o_busy[0]), 1);
    step();
    @(negedge clk);
    chk("tmo o_timeout", 32'(o_timeout[0]), 1);
    chk("tmo o_busy", 32'(o_busy[0]), 0);
    chk("tmo o_high kept", 32'(o_high[0]), 50);
    chk("tmo o_period kept", 32'(o_period[0]), 200);
    chk("tmo ch1 o_high kept", 32'(o_high[1]), 300);
    chk("tmo ch1 o_timeout", 32'(o_timeout[1]), 0);
    chk("tmo no valid", evq.size(), 0);

    // Clear and start together on ch1 while it is measuring the high phase.
    t0 = cyc + 12;
    gen_t0[1] = t0;
    gen_h[1]  = 300;
    gen_p[1]  = 500;
    gen_en[1] = 1'b1;
    wait_until(t0 - 5);
    start_pulse(2'b10);
    wait_until(t0 + 150);
    clear = 2'b10;
    start = 2'b10;
    step();
    clear = '0;
    start = '0;
    @(negedge clk);
    chk("clr o_high", 32'(o_high[1]), 0);
    chk("clr o_period", 32'(o_period[1]), 0);
    chk("clr o_done", 32'(o_done[1]), 0);
    chk("clr o_timeout", 32'(o_timeout[1]), 0);
    chk("clr o_busy", 32'(o_busy[1]), 0);
    chk("clr ch0 o_timeout kept", 32'(o_timeout[0]), 1);
    wait_until(t0 + 1200);
    @(negedge clk);
    #1;
    chk("clr no valid", count_ev(1), 0);
    chk("clr still idle", 32'(o_busy[1]), 0);

    // Reset during LOW, then a fresh capture.
    gen_en[1] = 1'b0;
    repeat (8) step();
    evq.delete();
    t0 = cyc + 12;
    gen_t0[0] = t0;
    gen_h[0]  = 100;
    gen_p[0]  = 400;
    gen_en[0] = 1'b1;
    wait_until(t0 - 5);
    start_pulse(2'b01);
    wait_until(t0 + 250);
    chk("pre-rst ch0 busy", 32'(o_busy[0]), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("rst-low ch%0d o_high", c), 32'(o_high[c]), 0);
      chk($sformatf("rst-low ch%0d o_period", c), 32'(o_period[c]), 0);
      chk($sformatf("rst-low ch%0d flags", c),
          32'({o_valid[c], o_done[c], o_timeout[c], o_busy[c]}), 0);
    end
    wait_until(t0 + 430);
    @(negedge clk);
    #1;
    chk("rst-low no valid", evq.size(), 0);
    run_vec(tbl[0], "post_rst");

    // Random duty/period pairs on both channels with coincident edges.
    for (int r = 0; r < 4; r++) begin
      rv.mask   = 2'b11;
      rv.cont   = 1'($urandom_range(1, 0));
      rv.p0     = $urandom_range(600, 30);
      rv.p1     = $urandom_range(600, 30);
      rv.h0     = $urandom_range(rv.p0 - 2, 2);
      rv.h1     = $urandom_range(rv.p1 - 2, 2);
      rv.nsched = 2;
      rv.eh0    = rv.h0;
      rv.ep0    = rv.p0;
      rv.eh1    = rv.h1;
      rv.ep1    = rv.p1;
      // In free-running mode a pulse lands every period after the first rising edge.
      rv.en0 = rv.cont ? (2 * ((rv.p0 > rv.p1) ? rv.p0 : rv.p1) + 20) / rv.p0 : 1;
      rv.en1 = rv.cont ? (2 * ((rv.p0 > rv.p1) ? rv.p0 : rv.p1) + 20) / rv.p1 : 1;
      run_vec(rv, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
